lavanderia: RTL and testbench

//   Coin-operated laundry controller. Counts coins while payment is open; on

---
 rtl/lavanderia_if.sv | 27 ++
 rtl/lavanderia.sv | 141 ++++++++++++++
 tb/tb_lavanderia.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lavanderia_if.sv
// rtl/lavanderia_if.sv - front-panel signal bundle for the laundry controller
interface lavanderia_if;
    logic intro_moneda;
    logic finalizar_pago;
    logic SECADO;
    logic LAVADO;
    logic LAVADO_PESADO;
    logic insuficiente;

    modport master (
        output intro_moneda,
        output finalizar_pago,
        input  SECADO,
        input  LAVADO,
        input  LAVADO_PESADO,
        input  insuficiente
    );

    modport slave (
        input  intro_moneda,
        input  finalizar_pago,
        output SECADO,
        output LAVADO,
        output LAVADO_PESADO,
        output insuficiente
    );
endinterface

// File: rtl/lavanderia.sv
// rtl/lavanderia.sv - coin-operated laundry controller: credit counting, service selection and timing
module lavanderia #(
    parameter int PRECIO_SECADO = 2,
    parameter int PRECIO_LAVADO = 3,
    parameter int PRECIO_PESADO = 4,
    parameter int DUR_SECADO    = 8,
    parameter int DUR_LAVADO    = 12,
    parameter int DUR_PESADO    = 16,
    parameter int CW            = 4
) (
    input  logic         clk,
    input  logic         rst,
    lavanderia_if.slave  bus
);

    localparam int DUR_MAX = (DUR_SECADO > DUR_LAVADO)
                           ? ((DUR_SECADO > DUR_PESADO) ? DUR_SECADO : DUR_PESADO)
                           : ((DUR_LAVADO > DUR_PESADO) ? DUR_LAVADO : DUR_PESADO);
    localparam int TW = $clog2(DUR_MAX + 1);

    localparam logic [CW-1:0] P_SEC = CW'(PRECIO_SECADO);
    localparam logic [CW-1:0] P_LAV = CW'(PRECIO_LAVADO);
    localparam logic [CW-1:0] P_PES = CW'(PRECIO_PESADO);
    localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
    localparam logic [TW-1:0] T_SEC = TW'(DUR_SECADO - 1);
    localparam logic [TW-1:0] T_LAV = TW'(DUR_LAVADO - 1);
    localparam logic [TW-1:0] T_PES = TW'(DUR_PESADO - 1);

    typedef enum logic [2:0] {
        IDLE,
        COBRO,
        S_SECADO,
        S_LAVADO,
        S_PESADO
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] credit, credit_n, credit_inc;
    logic [TW-1:0] timer, timer_n;
    logic          moneda_q;
    logic          coin;
    logic          sec_q, lav_q, pes_q, ins_q;
    logic          sec_n, lav_n, pes_n, ins_n;

    assign coin       = bus.intro_moneda & ~moneda_q;
    assign credit_inc = (coin && credit != C_MAX) ? credit + CW'(1) : credit;

    assign bus.SECADO        = sec_q;
    assign bus.LAVADO        = lav_q;
    assign bus.LAVADO_PESADO = pes_q;
    assign bus.insuficiente  = ins_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit   <= '0;
            timer    <= '0;
            moneda_q <= 1'b0;
            sec_q    <= 1'b0;
            lav_q    <= 1'b0;
            pes_q    <= 1'b0;
            ins_q    <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            timer    <= timer_n;
            moneda_q <= bus.intro_moneda;
            sec_q    <= sec_n;
            lav_q    <= lav_n;
            pes_q    <= pes_n;
            ins_q    <= ins_n;
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        timer_n  = timer;
        sec_n    = 1'b0;
        lav_n    = 1'b0;
        pes_n    = 1'b0;
        ins_n    = 1'b0;
        case (state)
            IDLE, COBRO: begin
                credit_n = credit_inc;
                if (coin) begin
                    state_n = COBRO;
                end
                // A coin arriving together with the payment request still counts.
                if (bus.finalizar_pago) begin
                    if (credit_inc >= P_PES) begin
                        state_n  = S_PESADO;
                        timer_n  = T_PES;
                        credit_n = '0;
                        pes_n    = 1'b1;
                    end else if (credit_inc >= P_LAV) begin
                        state_n  = S_LAVADO;
                        timer_n  = T_LAV;
                        credit_n = '0;
                        lav_n    = 1'b1;
                    end else if (credit_inc >= P_SEC) begin
                        state_n  = S_SECADO;
                        timer_n  = T_SEC;
                        credit_n = '0;
                        sec_n    = 1'b1;
                    end else begin
                        ins_n = 1'b1;
                    end
                end
            end
            S_SECADO: begin
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                    sec_n   = 1'b1;
                end
            end
            S_LAVADO: begin
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                    lav_n   = 1'b1;
                end
            end
            S_PESADO: begin
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                    pes_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lavanderia.sv
// tb/tb_lavanderia.sv - directed vector bench for the laundry controller
module tb_lavanderia;

    localparam logic [3:0] O_NONE = 4'b0000;
    localparam logic [3:0] O_SEC  = 4'b1000;
    localparam logic [3:0] O_LAV  = 4'b0100;
    localparam logic [3:0] O_PES  = 4'b0010;
    localparam logic [3:0] O_INS  = 4'b0001;

    typedef struct {
        logic       rst;
        logic       moneda;
        logic       fin;
        int         n;
        logic [3:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t tbl[$];

    lavanderia_if bus();

    lavanderia dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {bus.SECADO, bus.LAVADO, bus.LAVADO_PESADO, bus.insuficiente};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (SEC,LAV,PES,INS)", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic m, input logic f, input int n,
                        input logic [3:0] e, input string name);
        vec_t v;
        v.rst = r; v.moneda = m; v.fin = f; v.n = n; v.exp = e; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic step(input logic m, input logic f, input logic [3:0] e, input string name);
        bus.intro_moneda   = m;
        bus.finalizar_pago = f;
        tick();
        chk(name, outs(), e);
    endtask

    task automatic coins(input int k, input string name);
        for (int i = 0; i < k; i++) begin
            step(1'b1, 1'b0, O_NONE, name);
            step(1'b0, 1'b0, O_NONE, name);
        end
    endtask

    // Requests payment and measures how many cycles the expected output stays high.
    task automatic service(input int dur, input logic [3:0] e, input bit noise, input string name);
        int cnt;
        cnt = 0;
        bus.intro_moneda   = 1'b0;
        bus.finalizar_pago = 1'b1;
        tick();
        chk({name, " start"}, outs(), e);
        while (outs() == e && cnt < 40) begin
            cnt++;
            bus.intro_moneda   = noise ? cnt[0] : 1'b0;
            bus.finalizar_pago = noise ? cnt[1] : 1'b0;
            tick();
        end
        bus.intro_moneda   = 1'b0;
        bus.finalizar_pago = 1'b0;
        chk_int({name, " length"}, cnt, dur);
        chk({name, " end"}, outs(), O_NONE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.intro_moneda   = 1'b0;
        bus.finalizar_pago = 1'b0;

        addv(1, 0, 0, 2,  O_NONE, "t1 reset");
        addv(0, 1, 0, 1,  O_NONE, "t1 coin1");
        addv(0, 0, 0, 1,  O_NONE, "t1 idle");
        addv(0, 0, 1, 1,  O_INS,  "t1 insuf");
        addv(0, 0, 0, 1,  O_NONE, "t1 insuf drop");
        addv(0, 1, 0, 1,  O_NONE, "t1 coin2");
        addv(0, 0, 1, 1,  O_SEC,  "t1 sec start");
        addv(0, 0, 0, 7,  O_SEC,  "t1 sec run");
        addv(0, 0, 0, 2,  O_NONE, "t1 sec done");
        for (int i = 0; i < 3; i++) begin
            addv(0, 1, 0, 1, O_NONE, "t2 coin");
            addv(0, 0, 0, 1, O_NONE, "t2 gap");
        end
        addv(0, 0, 1, 1,  O_LAV,  "t2 lav start");
        addv(0, 0, 0, 11, O_LAV,  "t2 lav run");
        addv(0, 0, 0, 1,  O_NONE, "t2 lav done");
        addv(0, 0, 1, 1,  O_INS,  "t2 idle empty");
        addv(0, 0, 0, 1,  O_NONE, "t2 quiet");
        addv(0, 1, 0, 5,  O_NONE, "t4 held coin");
        addv(0, 0, 1, 1,  O_INS,  "t4 one coin");
        addv(0, 0, 0, 1,  O_NONE, "t4 quiet");
        addv(0, 1, 1, 1,  O_SEC,  "t5 same cycle");
        addv(0, 0, 0, 7,  O_SEC,  "t5 sec run");
        addv(0, 0, 0, 1,  O_NONE, "t5 sec done");

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                rst = tbl[i].rst;
                step(tbl[i].moneda, tbl[i].fin, tbl[i].exp, tbl[i].name);
            end
        end
        rst = 1'b0;

        coins(6, "t3 coins");
        service(16, O_PES, 1'b0, "t3 pesado");
        coins(2, "t3 coins2");
        service(8, O_SEC, 1'b0, "t3 no carry");

        coins(3, "t6 coins");
        service(12, O_LAV, 1'b1, "t6 lav noisy");
        step(1'b0, 1'b1, O_INS, "t6 ignored coins");
        step(1'b0, 1'b0, O_NONE, "t6 quiet");

        coins(3, "t6 coins2");
        step(1'b0, 1'b1, O_LAV, "t6 lav start");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, O_LAV, "t6 lav run");
        rst = 1'b1;
        step(1'b0, 1'b0, O_NONE, "t6 reset abort");
        step(1'b0, 1'b0, O_NONE, "t6 reset hold");
        rst = 1'b0;
        step(1'b0, 1'b1, O_INS, "t6 after reset");
        step(1'b0, 1'b0, O_NONE, "t6 quiet2");

        coins(20, "t6 coins20");
        service(16, O_PES, 1'b0, "t6 saturate");
        coins(18, "t6 coins18");
        service(16, O_PES, 1'b0, "t6 no wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
